// File: rtl/lm_555_pulse_meter_if.sv
// rtl/lm_555_pulse_meter_if.sv - pulse meter signal bundle
//
// Purpose: groups the measured pulse input and the measurement results.
// Ports (modport view):
//   master : drives pulse; observes high_time, low_time, period, meas_valid, stuck
//   slave  : the meter; samples pulse; drives the measurement results
interface lm_555_pulse_meter_if #(
  parameter int CNT_W = 16
);
  logic             pulse;
  logic [CNT_W-1:0] high_time;
  logic [CNT_W-1:0] low_time;
  logic [CNT_W:0]   period;
  logic             meas_valid;
  logic             stuck;

  modport master (
    output pulse,
    input  high_time, low_time, period, meas_valid, stuck
  );

  modport slave (
    input  pulse,
    output high_time, low_time, period, meas_valid, stuck
  );
endinterface

// File: rtl/lm_555_pulse_meter.sv
// rtl/lm_555_pulse_meter.sv - high/low/period meter for an asynchronous pulse train
//
// Purpose: measures the high and low phase lengths (in clk cycles) of the last
// complete period of an asynchronous pulse, flags a stuck input.
// Ports:
//   clk   : sole clock, rising edge
//   reset : synchronous, active-low
//   bus   : lm_555_pulse_meter_if.slave (pulse in; high_time, low_time,
//           period, meas_valid, stuck out)
module lm_555_pulse_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 4000
) (
  input logic                  clk,
  input logic                  reset,
  lm_555_pulse_meter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_t           state, state_n;
  logic             s1, s2, s3;
  logic [1:0]       warm;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [CNT_W-1:0] high_meas, high_meas_n;
  logic [CNT_W-1:0] high_time_n, low_time_n;
  logic [CNT_W:0]   period_n;
  logic             valid_n, stuck_n;
  logic             rise, fall, timeout;

  assign rise    = s2 & ~s3;
  assign fall    = ~s2 & s3;
  assign timeout = (cnt == TIMEOUT_CNT);
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    high_meas_n = high_meas;
    high_time_n = bus.high_time;
    low_time_n  = bus.low_time;
    period_n    = bus.period;
    valid_n     = 1'b0;
    stuck_n     = bus.stuck;
    case (state)
      IDLE: begin
        cnt_n = '0;
        // s1/s2 hold reset zeros for two cycles, not real samples; waiting for
        // warm[1] keeps a pulse that is already high at reset release from
        // looking like a low phase and being measured as a partial high.
        if (warm[1] && !s2) state_n = WAIT_RISE;
      end
      WAIT_RISE: begin
        cnt_n = '0;
        if (rise) begin
          state_n = HIGH;
          cnt_n   = CNT_W'(1);
        end
      end
      HIGH: begin
        if (timeout) begin
          state_n = IDLE;
          cnt_n   = '0;
          stuck_n = 1'b1;
        end else if (fall) begin
          state_n     = LOW;
          cnt_n       = CNT_W'(1);
          high_meas_n = cnt;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      LOW: begin
        // timeout wins over a rise seen in the same cycle
        if (timeout) begin
          state_n = IDLE;
          cnt_n   = '0;
          stuck_n = 1'b1;
        end else if (rise) begin
          state_n     = HIGH;
          cnt_n       = CNT_W'(1);
          high_time_n = high_meas;
          low_time_n  = cnt;
          period_n    = {1'b0, high_meas} + {1'b0, cnt};
          valid_n     = 1'b1;
          stuck_n     = 1'b0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      s1             <= 1'b0;
      s2             <= 1'b0;
      s3             <= 1'b0;
      warm           <= 2'b00;
      high_meas      <= '0;
      bus.high_time  <= '0;
      bus.low_time   <= '0;
      bus.period     <= '0;
      bus.meas_valid <= 1'b0;
      bus.stuck      <= 1'b0;
    end else begin
      s1             <= bus.pulse;
      s2             <= s1;
      s3             <= s2;
      warm           <= {warm[0], 1'b1};
      state          <= state_n;
      cnt            <= cnt_n;
      high_meas      <= high_meas_n;
      bus.high_time  <= high_time_n;
      bus.low_time   <= low_time_n;
      bus.period     <= period_n;
      bus.meas_valid <= valid_n;
      bus.stuck      <= stuck_n;
    end
  end

endmodule

// File: tb/tb_lm_555_pulse_meter.sv
// tb/tb_lm_555_pulse_meter.sv - directed bench for lm_555_pulse_meter
module tb_lm_555_pulse_meter;

  logic clk;
  logic reset;

  lm_555_pulse_meter_if #(.CNT_W(16)) a_if ();
  lm_555_pulse_meter_if #(.CNT_W(4))  b_if ();

  lm_555_pulse_meter #(.CNT_W(16), .TIMEOUT(4000)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if)
  );

  lm_555_pulse_meter #(.CNT_W(4), .TIMEOUT(15)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   va    = 0;
  int   vb    = 0;
  int   last_a = 0;
  int   prev_a = 0;
  logic stuck_at_va = 1'b0;
  int   v0;
  int   d0;

  // valid strobe monitor, sampled 1 ns after each rising edge
  always @(posedge clk) begin
    cyc++;
    #1;
    if (a_if.meas_valid === 1'b1) begin
      prev_a      = last_a;
      last_a      = cyc;
      va++;
      stuck_at_va = a_if.stuck;
    end
    if (b_if.meas_valid === 1'b1) vb++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic hold_a(input logic lvl, input int n);
    a_if.pulse = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_b(input logic lvl, input int n);
    b_if.pulse = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic lvl);
    reset      = 1'b0;
    a_if.pulse = lvl;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset      = 1'b0;
    a_if.pulse = 1'b1;
    b_if.pulse = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_high_time",  32'(a_if.high_time),  0);
    chk("rst_low_time",   32'(a_if.low_time),   0);
    chk("rst_period",     32'(a_if.period),     0);
    chk("rst_meas_valid", 32'(a_if.meas_valid), 0);
    chk("rst_stuck",      32'(a_if.stuck),      0);

    // pulse already high at reset release: partial high phase discarded
    reset = 1'b1;
    v0 = va;
    hold_a(1'b1, 100);
    chk("partial_no_valid", 32'(va - v0), 0);
    hold_a(1'b0, 20);
    hold_a(1'b1, 7);
    hold_a(1'b0, 9);
    chk("partial_still_no_valid", 32'(va - v0), 0);
    d0 = cyc;
    hold_a(1'b1, 4);
    chk("partial_valid_cnt", 32'(va - v0), 1);
    chk("partial_high", 32'(a_if.high_time), 7);
    chk("partial_low",  32'(a_if.low_time),  9);
    chk("partial_per",  32'(a_if.period),    16);
    chk("latency_a",    32'(last_a),         32'(d0 + 3));

    // 353 high / 346 low repeated
    do_reset(1'b0);
    v0 = va;
    hold_a(1'b0, 10);
    for (int i = 0; i < 3; i++) begin
      hold_a(1'b1, 353);
      hold_a(1'b0, 346);
    end
    d0 = cyc;
    hold_a(1'b1, 5);
    chk("astable_valid_cnt", 32'(va - v0), 3);
    chk("astable_high",   32'(a_if.high_time), 353);
    chk("astable_low",    32'(a_if.low_time),  346);
    chk("astable_period", 32'(a_if.period),    699);
    chk("astable_spacing", 32'(last_a - prev_a), 699);
    chk("astable_latency", 32'(last_a), 32'(d0 + 3));
    chk("astable_stuck",  32'(a_if.stuck), 0);

    // 1/1 alternating
    do_reset(1'b0);
    v0 = va;
    hold_a(1'b0, 4);
    for (int i = 0; i < 8; i++) begin
      hold_a(1'b1, 1);
      hold_a(1'b0, 1);
    end
    hold_a(1'b0, 3);
    chk("fast_valid_cnt", 32'(va - v0), 7);
    chk("fast_high",    32'(a_if.high_time), 1);
    chk("fast_low",     32'(a_if.low_time),  1);
    chk("fast_period",  32'(a_if.period),    2);
    chk("fast_spacing", 32'(last_a - prev_a), 2);

    // low held exactly TIMEOUT cycles: timeout beats the following rise
    do_reset(1'b0);
    v0 = va;
    hold_a(1'b0, 4);
    hold_a(1'b1, 10);
    hold_a(1'b0, 4000);
    hold_a(1'b1, 10);
    chk("to_stuck",     32'(a_if.stuck),     1);
    chk("to_no_valid",  32'(va - v0),        0);
    chk("to_high_kept", 32'(a_if.high_time), 0);
    hold_a(1'b0, 10);
    hold_a(1'b1, 10);
    hold_a(1'b0, 10);
    hold_a(1'b1, 3);
    chk("rec_valid_cnt", 32'(va - v0), 1);
    chk("rec_high",   32'(a_if.high_time), 10);
    chk("rec_low",    32'(a_if.low_time),  10);
    chk("rec_period", 32'(a_if.period),    20);
    chk("rec_stuck",  32'(a_if.stuck),     0);
    chk("rec_stuck_at_valid", 32'(stuck_at_va), 0);

    // one-cycle reset in the middle of a high phase
    hold_a(1'b0, 5);
    hold_a(1'b1, 6);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("mid_rst_high",   32'(a_if.high_time),  0);
    chk("mid_rst_low",    32'(a_if.low_time),   0);
    chk("mid_rst_period", 32'(a_if.period),     0);
    chk("mid_rst_valid",  32'(a_if.meas_valid), 0);
    chk("mid_rst_stuck",  32'(a_if.stuck),      0);
    v0 = va;
    hold_a(1'b1, 5);
    hold_a(1'b0, 7);
    hold_a(1'b1, 8);
    hold_a(1'b0, 9);
    chk("mid_rst_no_valid", 32'(va - v0), 0);
    hold_a(1'b1, 3);
    chk("mid_rst_valid_cnt", 32'(va - v0), 1);
    chk("mid_rst_new_high",  32'(a_if.high_time), 8);
    chk("mid_rst_new_low",   32'(a_if.low_time),  9);
    chk("mid_rst_new_per",   32'(a_if.period),    17);

    // CNT_W=4, TIMEOUT=15: stuck at count 15, no wrap
    hold_b(1'b0, 4);
    hold_b(1'b1, 17);
    chk("b_not_yet_stuck", 32'(b_if.stuck), 0);
    hold_b(1'b1, 3);
    chk("b_stuck",     32'(b_if.stuck),     1);
    chk("b_high_time", 32'(b_if.high_time), 0);
    chk("b_no_valid",  32'(vb),             0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lm_555_pulse_meter.md
LM_555_PULSE_METER -- requirements
Module: lm_555_pulse_meter

Interface
REQ-001 Parameter CNT_W, default 16: width of the high_time and low_time counters and outputs.
REQ-002 Parameter TIMEOUT, default 4000: idle-phase limit in clk cycles; the block SHALL require 1 < TIMEOUT <= 2^CNT_W-1.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled only on rising clk edges.
REQ-005 pulse  input  1  asynchronous pulse train to measure, e.g. the astable 555 timer output.
REQ-006 high_time  output  CNT_W  clk cycles pulse was high in the last complete period.
REQ-007 low_time  output  CNT_W  clk cycles pulse was low in the last complete period.
REQ-008 period  output  CNT_W+1  high_time + low_time, with no overflow.
REQ-009 meas_valid  output  1  one-cycle strobe when high_time, low_time and period update.
REQ-010 stuck  output  1  pulse held one level for TIMEOUT cycles; sticky until the next meas_valid or reset.

Function
REQ-011 pulse SHALL pass through a 2-flop synchronizer (s1, s2) and a third flop s3.
REQ-012 Edge detection: rise = s2 & ~s3; fall = ~s2 & s3.
REQ-013 FSM states SHALL be IDLE, WAIT_RISE, HIGH and LOW, with phase counter cnt of CNT_W bits.
REQ-014 IDLE: s2==0 -> WAIT_RISE; otherwise stay, which discards partial high phases.
REQ-015 WAIT_RISE: rise -> HIGH with cnt=1; the first high phase is measured, but no low phase is measured before it.
REQ-016 HIGH: fall -> LOW with cnt=1 and high_time latched internally as cnt; otherwise cnt+1, saturating at 2^CNT_W-1.
REQ-017 LOW: rise -> HIGH with cnt=1, and low_time, high_time and period updated from cnt and the latched high value; otherwise cnt+1, saturating.
REQ-018 meas_valid SHALL assert exactly one cycle, registered, in the cycle after the LOW->HIGH rise is detected; outputs change only in that cycle.
REQ-019 Latency: pulse rising at sample edge k -> rise seen after edge k+2 -> meas_valid high after edge k+3.
REQ-020 Width rule: a pulse level held N sampled cycles SHALL yield a count of N.
REQ-021 Timeout applies in HIGH or LOW only: cnt==TIMEOUT without an edge -> stuck=1, FSM -> IDLE, no meas_valid, outputs unchanged.
REQ-022 Timeout SHALL take priority over an edge detected in the same cycle.
REQ-023 stuck SHALL clear in the same cycle meas_valid asserts.
REQ-024 A 1-cycle glitch SHALL be measured as a phase of length 1; no filtering is applied.

Reset
REQ-025 reset==0 at a clk edge SHALL set FSM=IDLE, cnt=0, s1=s2=s3=0, high_time=low_time=0, period=0, meas_valid=0, stuck=0.
REQ-026 Reset asserted mid-measurement SHALL discard the phase in progress; after release, measurement restarts from IDLE.

Verification
REQ-027 Scenario: reset, then pulse 353 high / 346 low repeated -> first meas_valid after the second rise; high_time=353, low_time=346, period=699; repeats every 699 cycles.
REQ-028 Scenario: pulse starts high at reset release for 100 cycles -> no meas_valid for that partial phase; the first valid reports only full phases.
REQ-029 Scenario: TIMEOUT=4000, pulse held low 4000 cycles after a high phase -> stuck=1, no valid; a later clean period of 10/10 -> meas_valid, high_time=10, low_time=10, period=20, stuck=0.
REQ-030 Scenario: 1 cycle high / 1 cycle low alternating -> meas_valid every 2 cycles; high_time=1, low_time=1, period=2.
REQ-031 Scenario: reset pulsed low for one cycle during a HIGH phase -> all outputs 0; the next valid requires a fresh low->high->low->high sequence.
REQ-032 Scenario: CNT_W=4, TIMEOUT=15, high 20 cycles -> stuck=1 at cnt 15, no wrap; high_time stays 0.
